// File: rtl/barrel_pkg.sv
// rtl/barrel_pkg.sv - shared constants, mode encodings and shift helper for the barrel units
//
// Purpose : default geometry of the rotator datapath, the rotate/shift mode
//           encoding and a reference rotate/shift-left-by-2^k function.
// Ports   : none (package).
package barrel_pkg;

  localparam int BRL_WIDTH = 8;
  localparam int BRL_SHW   = 3;

  localparam logic BRL_MODE_ROL = 1'b0;
  localparam logic BRL_MODE_SHL = 1'b1;

  // Rotate (mode=ROL) or zero-fill shift (mode=SHL) left by 2^k, k < BRL_SHW.
  function automatic logic [BRL_WIDTH-1:0] brl_shl_pow2(
    input logic [BRL_WIDTH-1:0] d,
    input int unsigned          k,
    input logic                 mode
  );
    int unsigned amt;
    amt = 32'd1 << k;
    if (mode == BRL_MODE_SHL)
      return d << amt;
    else
      return (d << amt) | (d >> (BRL_WIDTH - amt));
  endfunction

endpackage

// File: rtl/barrel_rol_pipe_if.sv
// rtl/barrel_rol_pipe_if.sv - producer/consumer handshake bundle of the left rotator
//
// Purpose : groups the input word handshake, output word handshake and the
//           busy flag of barrel_rol_pipe.
// Signals : in_valid/in_ready/data_in/sel/mode  - producer side
//           out_valid/out_ready/data_out        - consumer side
//           busy                                - any stage occupied
// Modports: slave  - the rotator itself
//           master - the environment driving it
interface barrel_rol_pipe_if
  import barrel_pkg::*;
#(
  parameter int WIDTH = BRL_WIDTH,
  parameter int SHW   = BRL_SHW
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic [SHW-1:0]   sel;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             busy;

  modport slave (
    input  in_valid, data_in, sel, mode, out_ready,
    output in_ready, out_valid, data_out, busy
  );

  modport master (
    output in_valid, data_in, sel, mode, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

endinterface

// File: rtl/barrel_rol_stage.sv
// rtl/barrel_rol_stage.sv - one registered stage of the logarithmic left rotator
//
// Purpose : applies sel bit STAGE (rotate or shift left by 2^STAGE) and
//           registers the word together with its sel/mode so later stages
//           see the values captured with the word.
// Ports   : clk, reset            - clock, async active-high reset
//           valid_in/data_in/sel_in/mode_in - word from upstream
//           ready_in              - downstream stage (or consumer) will load
//           valid_out/data_out/sel_out/mode_out - registered stage contents
//           ready_out             - this stage loads on the next edge
module barrel_rol_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = BRL_WIDTH,
  parameter int SHW   = BRL_SHW,
  parameter int STAGE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   sel_in,
  input  logic             mode_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
  output logic [SHW-1:0]   sel_out,
  output logic             mode_out,
  output logic             ready_out
);

  localparam int AMT = 1 << STAGE;

  logic [WIDTH-1:0] rol_d;
  logic [WIDTH-1:0] shl_d;
  logic [WIDTH-1:0] next_d;

  assign rol_d = (data_in << AMT) | (data_in >> (WIDTH - AMT));
  assign shl_d = data_in << AMT;

  always_comb begin
    next_d = data_in;
    if (sel_in[STAGE])
      next_d = (mode_in == BRL_MODE_SHL) ? shl_d : rol_d;
  end

  // An empty slot always loads, so bubbles collapse as words move forward.
  assign ready_out = !valid_out || ready_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      sel_out   <= '0;
      mode_out  <= 1'b0;
    end else if (ready_out) begin
      valid_out <= valid_in;
      // Payload only moves with a real word; a bubble leaves it untouched.
      if (valid_in) begin
        data_out <= next_d;
        sel_out  <= sel_in;
        mode_out <= mode_in;
      end
    end
  end

endmodule

// File: rtl/barrel_rol_pipe.sv
// rtl/barrel_rol_pipe.sv - pipelined logarithmic rotate/shift-left unit with valid/ready
//
// Purpose : SHW chained barrel_rol_stage instances; stage k applies sel bit k.
//           One word per clock when not stalled, latency SHW edges.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous active-high reset
//           bus   - barrel_rol_pipe_if.slave (input/output handshakes, busy)
module barrel_rol_pipe
  import barrel_pkg::*;
#(
  parameter int WIDTH = BRL_WIDTH,
  parameter int SHW   = BRL_SHW
) (
  input  logic              clk,
  input  logic              reset,
  barrel_rol_pipe_if.slave  bus
);

  generate
    if (WIDTH < 2 || WIDTH != (1 << SHW)) begin : g_bad_param
      $error("barrel_rol_pipe: WIDTH must be a power of two >= 2 and equal 2**SHW");
    end
  endgenerate

  // Index 0 is the pipe input; index k+1 is stage k's registered output.
  logic [SHW:0]     v;
  logic [SHW:0]     r;
  logic [SHW:0]     m;
  logic [WIDTH-1:0] d [SHW+1];
  logic [SHW-1:0]   s [SHW+1];

  assign v[0]   = bus.in_valid;
  assign d[0]   = bus.data_in;
  assign s[0]   = bus.sel;
  assign m[0]   = bus.mode;
  assign r[SHW] = bus.out_ready;

  generate
    for (genvar k = 0; k < SHW; k++) begin : g_stage
      barrel_rol_stage #(
        .WIDTH (WIDTH),
        .SHW   (SHW),
        .STAGE (k)
      ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (v[k]),
        .data_in   (d[k]),
        .sel_in    (s[k]),
        .mode_in   (m[k]),
        .ready_in  (r[k+1]),
        .valid_out (v[k+1]),
        .data_out  (d[k+1]),
        .sel_out   (s[k+1]),
        .mode_out  (m[k+1]),
        .ready_out (r[k])
      );
    end
  endgenerate

  assign bus.in_ready  = r[0];
  assign bus.out_valid = v[SHW];
  assign bus.data_out  = d[SHW];
  assign bus.busy      = |v[SHW:1];

  // The last stage's carried sel/mode have no consumer.
  logic unused_tail;
  assign unused_tail = ^{s[SHW], m[SHW]};

endmodule
